// File: rtl/sx_demux.sv
// Per-ingress AXI-Stream packet router: steers whole packets to one of M_DATA_COUNT outputs
// through a 2-entry skid buffer. Define SX_DEMUX_DROP_CNT_EN to add the drop_cnt_o counter.
module sx_demux #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned M_DATA_COUNT = 2,
  localparam int unsigned DEST_WIDTH  = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1,
  localparam int unsigned KEEP_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [DATA_WIDTH-1:0]                    s_axis_data_i,
  input  logic [KEEP_WIDTH-1:0]                    s_axis_keep_i,
  input  logic                                     s_axis_last_i,
  input  logic [DEST_WIDTH-1:0]                    s_axis_dest_i,
  input  logic                                     s_axis_valid_i,
  output logic                                     s_axis_ready_o,
  output logic [M_DATA_COUNT-1:0][DATA_WIDTH-1:0]  m_axis_data_o,
  output logic [M_DATA_COUNT-1:0][KEEP_WIDTH-1:0]  m_axis_keep_o,
  output logic [M_DATA_COUNT-1:0]                  m_axis_last_o,
  output logic [M_DATA_COUNT-1:0]                  m_axis_valid_o,
  input  logic [M_DATA_COUNT-1:0]                  m_axis_ready_i
`ifdef SX_DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]                              drop_cnt_o
`endif
);

  typedef enum logic [1:0] {SmFirst, SmRoute, SmDrop} state_e;

  localparam logic [DEST_WIDTH:0] MCount = (DEST_WIDTH + 1)'(M_DATA_COUNT);

  state_e                state_q, state_d;
  logic [DEST_WIDTH-1:0] dest_q;
  logic                  head_valid_q, skid_valid_q;
  logic [DATA_WIDTH-1:0] head_data_q, skid_data_q;
  logic [KEEP_WIDTH-1:0] head_keep_q, skid_keep_q;
  logic                  head_last_q, skid_last_q;
  logic [DEST_WIDTH-1:0] head_tag_q, skid_tag_q;

  logic [DEST_WIDTH-1:0] in_dest, push_tag;
  logic                  in_oor, in_xfer, push, pop;

  // A single output has nowhere else to go, so its tag is forced to 0.
  assign in_dest = (M_DATA_COUNT == 1) ? '0 : s_axis_dest_i;
  assign in_oor  = ({1'b0, in_dest} >= MCount);

  // Discarded beats never touch the buffer, so they are accepted even when it is full.
  assign s_axis_ready_o = ~reset & ((state_q == SmDrop) | ~skid_valid_q |
                                    ((state_q == SmFirst) & in_oor));
  assign in_xfer  = s_axis_valid_i & s_axis_ready_o;
  assign push     = in_xfer & ((state_q == SmRoute) | ((state_q == SmFirst) & ~in_oor));
  assign push_tag = (state_q == SmFirst) ? in_dest : dest_q;

  always_comb begin
    for (int p = 0; p < int'(M_DATA_COUNT); p++) begin
      m_axis_data_o[p]  = head_data_q;
      m_axis_keep_o[p]  = head_keep_q;
      m_axis_last_o[p]  = head_last_q;
      m_axis_valid_o[p] = ~reset & head_valid_q & (head_tag_q == DEST_WIDTH'(p));
    end
  end

  assign pop = |(m_axis_valid_o & m_axis_ready_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      SmFirst: if (in_xfer && !s_axis_last_i) state_d = in_oor ? SmDrop : SmRoute;
      SmRoute, SmDrop: if (in_xfer && s_axis_last_i) state_d = SmFirst;
      default: state_d = SmFirst;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SmFirst;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push && state_q == SmFirst) dest_q <= in_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      head_keep_q  <= '0;
      head_last_q  <= 1'b0;
      head_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_keep_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_tag_q   <= '0;
    end else if (pop) begin
      if (skid_valid_q) begin
        head_data_q  <= skid_data_q;
        head_keep_q  <= skid_keep_q;
        head_last_q  <= skid_last_q;
        head_tag_q   <= skid_tag_q;
        skid_valid_q <= 1'b0;
      end else if (push) begin
        head_data_q <= s_axis_data_i;
        head_keep_q <= s_axis_keep_i;
        head_last_q <= s_axis_last_i;
        head_tag_q  <= push_tag;
      end else begin
        head_valid_q <= 1'b0;
      end
    end else if (push) begin
      if (!head_valid_q) begin
        head_valid_q <= 1'b1;
        head_data_q  <= s_axis_data_i;
        head_keep_q  <= s_axis_keep_i;
        head_last_q  <= s_axis_last_i;
        head_tag_q   <= push_tag;
      end else begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= s_axis_data_i;
        skid_keep_q  <= s_axis_keep_i;
        skid_last_q  <= s_axis_last_i;
        skid_tag_q   <= push_tag;
      end
    end
  end

`ifdef SX_DEMUX_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (in_xfer && state_q == SmFirst && in_oor && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sx_demux.sv
// Directed bench for sx_demux (M_DATA_COUNT=3, DATA_WIDTH=16) with a scoreboard queue
// filled at input transfers and drained by an output monitor.
module tb_sx_demux;
  localparam int DW = 16;
  localparam int KW = DW / 8;
  localparam int M  = 3;
  localparam int DESTW = 2;

  typedef struct packed {
    logic [1:0]    port;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0]         s_data = '0;
  logic [KW-1:0]         s_keep = '0;
  logic                  s_last = 1'b0;
  logic [DESTW-1:0]      s_dest = '0;
  logic                  s_valid = 1'b0;
  logic                  s_ready;
  logic [M-1:0][DW-1:0]  m_data;
  logic [M-1:0][KW-1:0]  m_keep;
  logic [M-1:0]          m_last;
  logic [M-1:0]          m_valid;
  logic [M-1:0]          m_ready = '0;
`ifdef SX_DEMUX_DROP_CNT_EN
  logic [15:0]           drop_cnt;
`endif

  beat_t exp_q[$];
  int    n_assert = 0;
  int    n_fail = 0;
  int    n_out = 0;
  int    base;
  bit    done;

  logic [M-1:0]  pv = '0;
  logic [M-1:0]  pr = '0;
  logic [DW-1:0] pd = '0;
  logic [KW-1:0] pk = '0;
  logic          pl = 1'b0;

  always #5 clk = ~clk;

  sx_demux #(.DATA_WIDTH(DW), .M_DATA_COUNT(M)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_axis_data_i  (s_data),
    .s_axis_keep_i  (s_keep),
    .s_axis_last_i  (s_last),
    .s_axis_dest_i  (s_dest),
    .s_axis_valid_i (s_valid),
    .s_axis_ready_o (s_ready),
    .m_axis_data_o  (m_data),
    .m_axis_keep_o  (m_keep),
    .m_axis_last_o  (m_last),
    .m_axis_valid_o (m_valid),
    .m_axis_ready_i (m_ready)
`ifdef SX_DEMUX_DROP_CNT_EN
    ,
    .drop_cnt_o     (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one beat (entered at posedge+1); record the expectation once it is accepted.
  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                      input logic [DESTW-1:0] dst, input logic [1:0] port, input bit drop);
    int guard = 0;
    bit ok = 1'b1;
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_dest  = dst;
    @(negedge clk);
    while (!s_ready) begin
      guard++;
      if (guard > 200) begin
        chk("send_timeout", 64'(s_ready), 64'd1);
        ok = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (ok && !drop) exp_q.push_back('{port: port, data: d, keep: k, last: l});
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Output monitor: one-hot valid, hold-while-stalled, and scoreboard compare.
  always @(negedge clk) begin
    if (reset) begin
      pv <= '0;
      pr <= '0;
    end else begin
      if (|m_valid) chk("valid_onehot", 64'($countones(m_valid)), 64'd1);
      if (|(pv & ~pr)) begin
        chk("hold_valid", 64'(m_valid), 64'(pv));
        chk("hold_data", 64'(m_data[0]), 64'(pd));
        chk("hold_keep", 64'(m_keep[0]), 64'(pk));
        chk("hold_last", 64'(m_last[0]), 64'(pl));
      end
      for (int p = 0; p < M; p++) begin
        if (m_valid[p] && m_ready[p]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("out_port", 64'(p), 64'(e.port));
            chk("out_data", 64'(m_data[p]), 64'(e.data));
            chk("out_keep", 64'(m_keep[p]), 64'(e.keep));
            chk("out_last", 64'(m_last[p]), 64'(e.last));
          end
          n_out++;
        end
      end
      pv <= m_valid;
      pr <= m_ready;
      pd <= m_data[0];
      pk <= m_keep[0];
      pl <= m_last[0];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data[1]), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", 64'(s_ready), 64'd1);
    chk("idle_m_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;

    // 3-beat packet to port 2, 1-cycle latency
    m_ready = '1;
    send(16'h2001, 2'b11, 1'b0, 2'd2, 2'd2, 1'b0);
    @(negedge clk);
    chk("latency_valid", 64'(m_valid), 64'b100);
    chk("latency_data", 64'(m_data[2]), 64'h2001);
    @(posedge clk);
    #1;
    send(16'h2002, 2'b11, 1'b0, 2'd0, 2'd2, 1'b0);
    send(16'h2003, 2'b01, 1'b1, 2'd1, 2'd2, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back packets, no bubbles
    base = n_out;
    send(16'h3001, 2'b11, 1'b0, 2'd1, 2'd1, 1'b0);
    send(16'h3002, 2'b11, 1'b1, 2'd1, 2'd1, 1'b0);
    send(16'h3003, 2'b10, 1'b1, 2'd2, 2'd2, 1'b0);
    chk("b2b_count", 64'(n_out - base), 64'd2);
    @(negedge clk);
    chk("b2b_port", 64'(m_valid), 64'b100);
    @(posedge clk);
    #1;

    // Backpressure: ready drops after two buffered beats; later dest changes ignored
    m_ready = '0;
    send(16'h4001, 2'b11, 1'b0, 2'd0, 2'd0, 1'b0);
    send(16'h4002, 2'b11, 1'b0, 2'd1, 2'd0, 1'b0);
    @(negedge clk);
    chk("bp_s_ready", 64'(s_ready), 64'd0);
    chk("bp_valid", 64'(m_valid), 64'b001);
    chk("bp_data", 64'(m_data[0]), 64'h4001);
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_data", 64'(m_data[0]), 64'h4001);
    end
    @(posedge clk);
    #1 m_ready = 3'b001;
    send(16'h4003, 2'b11, 1'b0, 2'd2, 2'd0, 1'b0);
    send(16'h4004, 2'b01, 1'b1, 2'd3, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Out-of-range dest dropped even while the buffer is full
    m_ready = '0;
    send(16'h5001, 2'b11, 1'b1, 2'd1, 2'd1, 1'b0);
    send(16'h5002, 2'b11, 1'b1, 2'd1, 2'd1, 1'b0);
    for (int i = 0; i < 5; i++) send(16'h50A0 + 16'(i), 2'b11, i == 4, 2'd3, 2'd0, 1'b1);
    m_ready = '1;
    send(16'h5100, 2'b11, 1'b1, 2'd0, 2'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
`ifdef SX_DEMUX_DROP_CNT_EN
    chk("drop_cnt", 64'(drop_cnt), 64'd1);
`endif

    // Reset mid-packet with two beats buffered
    m_ready = '0;
    send(16'h6001, 2'b11, 1'b0, 2'd2, 2'd2, 1'b0);
    send(16'h6002, 2'b11, 1'b0, 2'd2, 2'd2, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_valid", 64'(m_valid), 64'd0);
    chk("mrst_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'(m_valid), 64'd0);
    chk("post_rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1 m_ready = '1;
    send(16'h6100, 2'b11, 1'b1, 2'd1, 2'd1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Single-beat packets alternating 0/1 with random ready
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(16'h7000 + 16'(i), 2'(i), 1'b1, 2'(i % 2), 2'(i % 2), 1'b0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 m_ready = 3'($urandom_range(0, 7));
        end
      end
    join
    m_ready = '1;
    for (int g = 0; g < 50 && exp_q.size() != 0; g++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("total_out", 64'(n_out), 64'd54);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
